mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM between the IF fetch port and the EXE/MEM data port.
//  Both requesters use a req/addr_ok/data_ok handshake. The arbiter pipelines grants: at most one
//  access issues per cycle, and its response returns one cycle later, tagged with its owner.
//  Sits between the pipeline stages and the unified SRAM, below the top-level CPU wrapper.
// PARAMETERS
//  ADDR_W      32  address width (byte address)
//  DATA_W      32  data width; strobe width = DATA_W/8
//  STARVE_MAX  4   max consecutive data grants while inst_req is held; the next grant is forced to inst
// PORTS
//  clk           in   1        clock, rising edge
//  resetn        in   1        asynchronous active-low reset
//  inst_req      in   1        fetch request (read only)
//  inst_addr     in   ADDR_W   fetch address
//  inst_cancel   in   1        discard any in-flight fetch response (branch/flush)
//  inst_addr_ok  out  1        fetch accepted this cycle
//  inst_data_ok  out  1        fetch data valid this cycle
//  inst_rdata    out  DATA_W   fetch data
//  data_req      in   1        data request
//  data_wr       in   1        1 = write, 0 = read
//  data_wstrb    in   DATA_W/8 byte write enables (writes only)
//  data_addr     in   ADDR_W   data address
//  data_wdata    in   DATA_W   write data
//  data_addr_ok  out  1        data request accepted this cycle
//  data_data_ok  out  1        read data valid / write done this cycle
//  data_rdata    out  DATA_W   read data
//  sram_en       out  1        SRAM chip enable
//  sram_we       out  DATA_W/8 SRAM byte write enable
//  sram_addr     out  ADDR_W   SRAM address
//  sram_wdata    out  DATA_W   SRAM write data
//  sram_rdata    in   DATA_W   SRAM read data, valid the cycle after sram_en
// BEHAVIOUR
//  - Reset (async assert, state cleared immediately): resp_vld=0, resp_owner=INST, starve_cnt=0,
//    rr_last=DATA. While resetn=0, all *_addr_ok, *_data_ok, sram_en and sram_we are 0.
//  - Grant (combinational, one winner per cycle):
//    - Fixed priority: data wins over inst.
//    - Exception: if inst_req=1 and starve_cnt==STARVE_MAX, inst wins.
//  - Issue: the winner gets *_addr_ok=1, sram_en=1, and its addr is driven to the SRAM.
//    - sram_we = data_wstrb only for a data write; otherwise 0.
//    - No winner: sram_en=0, sram_we=0.
//  - Response tag: on issue, resp_vld<=1 and resp_owner<=winner; with no issue, resp_vld<=0.
//    - Next cycle, if resp_vld, assert the owner's *_data_ok for exactly 1 cycle.
//    - *_rdata = sram_rdata, passed through combinationally; meaningful only while data_ok=1.
//  - Latency: addr_ok in cycle t gives data_ok in cycle t+1, for reads and writes alike.
//    Back-to-back issue every cycle is allowed. There is no response back-pressure.
//  - inst_cancel: if it is high while resp_owner=INST and resp_vld=1, inst_data_ok is suppressed
//    this cycle. An inst request accepted in the same cycle as inst_cancel is NOT cancelled.
//  - starve_cnt:
//    - +1, saturating at STARVE_MAX, when data is granted while inst_req=1.
//    - Cleared when inst is granted, or when inst_req=0.
//  - Simultaneous first requests out of reset follow the normal grant rules; no special case.
//  - Reset mid-operation: a pending response is dropped and no data_ok appears after resetn rises.
// CONFIGURATION
//  ARB_RR_EN defined:
//    - Round-robin replaces fixed priority: on conflict, the requester not in rr_last wins.
//    - rr_last<=winner on every issue. starve_cnt is unused and held at 0.
//  ARB_RR_EN undefined: fixed priority with the starvation guard, as above.
// STRUCTURE
//  - Shared package mem_arb_pkg:
//    - owner encoding OWN_INST=1'b0, OWN_DATA=1'b1;
//    - default ADDR_W/DATA_W localparams;
//    - response-tag struct {vld, owner}.
//  - One sub-module arb_grant_sel: combinational winner select.
//    - Inputs: inst_req, data_req, starve_cnt, rr_last. Outputs: gnt_inst, gnt_data.
//    - Holds the ARB_RR_EN switch.
//  - The top keeps the tag and counter registers and the SRAM muxing.
// TESTING
//  - Reset mid-stream: assert resetn=0 with resp_vld=1 -> both data_ok stay 0 in the following
//    cycles; sram_en=0 while in reset.
//  - Inst only: inst_req=1, addr 0x1C000000, sram_rdata=0x02800C0C -> inst_addr_ok at t,
//    inst_data_ok=1 at t+1 with inst_rdata=0x02800C0C, sram_we=0.
//  - Conflict, fixed priority: both req every cycle with data_wr=0 ->
//    data, data, data, data, inst, data, ... (STARVE_MAX=4). Each data_ok appears 1 cycle after
//    its addr_ok.
//  - Write: data_req=1, data_wr=1, wstrb=4'b0011, addr 0x100, wdata 0xDEADBEEF ->
//    sram_we=4'b0011 the same cycle, data_data_ok=1 next cycle.
//  - Cancel: inst issued at t, inst_cancel=1 at t+1 -> no inst_data_ok at t+1; an inst
//    issued at t+1 returns its data_ok at t+2.
//  - ARB_RR_EN build: both req continuously -> grants alternate inst, data, inst, ...;
//    the first grant goes to inst, since rr_last=DATA after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: owner encoding, response tag, default widths.
// Optional build macro used by this slice: ARB_RR_EN (round-robin instead of fixed priority).
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } resp_tag_t;

  localparam resp_tag_t RESP_TAG_RST = '{vld: 1'b0, owner: OWN_INST};

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the SRAM port around the arbiter.
// slave = arbiter view, master = pipeline/SRAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_cancel;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  logic                  sram_en;
  logic [DATA_W/8-1:0]   sram_we;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W-1:0]     sram_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/arb_grant_sel.sv
// Combinational winner select for the shared SRAM port; one grant at most per cycle.
// ARB_RR_EN selects round-robin on conflict, otherwise data-first with a starvation guard.
module arb_grant_sel
  import mem_arb_pkg::*;
#(
  parameter int  STARVE_MAX = STARVE_MAX_DEF,
  localparam int CNT_W      = cnt_w(STARVE_MAX)
) (
  input  logic             inst_req,
  input  logic             data_req,
  input  logic [CNT_W-1:0] starve_cnt,
  input  owner_e           rr_last,
  output logic             gnt_inst,
  output logic             gnt_data
);

`ifdef ARB_RR_EN
  logic unused_starve;
  assign unused_starve = ^starve_cnt;

  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (inst_req && data_req) begin
      // On conflict the side that did not win last time goes now.
      gnt_inst = (rr_last == OWN_DATA);
      gnt_data = (rr_last == OWN_INST);
    end else begin
      gnt_inst = inst_req;
      gnt_data = data_req;
    end
  end
`else
  logic unused_rr_last;
  logic force_inst;
  assign unused_rr_last = rr_last;

  always_comb begin
    force_inst = inst_req && (starve_cnt == CNT_W'(STARVE_MAX));
    gnt_inst   = force_inst || (inst_req && !data_req);
    gnt_data   = data_req && !force_inst;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch port and the data port,
// returning each response one cycle after issue. Build macro: ARB_RR_EN (round-robin).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  ADDR_W     = ADDR_W_DEF,
  parameter int  DATA_W     = DATA_W_DEF,
  parameter int  STARVE_MAX = STARVE_MAX_DEF,
  localparam int CNT_W      = cnt_w(STARVE_MAX)
) (
  input  logic              clk,
  input  logic              resetn,
  mem_port_arbiter_if.slave bus
);

  resp_tag_t           resp_q, resp_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  owner_e              rr_last_q, rr_last_d;

  logic                gnt_inst;
  logic                gnt_data;
  logic                issue;
  logic [ADDR_W-1:0]   issue_addr;
  logic [DATA_W-1:0]   issue_wdata;

  arb_grant_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant_sel (
    .inst_req   (bus.inst_req),
    .data_req   (bus.data_req),
    .starve_cnt (starve_cnt_q),
    .rr_last    (rr_last_q),
    .gnt_inst   (gnt_inst),
    .gnt_data   (gnt_data)
  );

  assign issue = gnt_inst | gnt_data;

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_q       <= RESP_TAG_RST;
      starve_cnt_q <= '0;
      rr_last_q    <= OWN_DATA;
    end else begin
      resp_q       <= resp_d;
      starve_cnt_q <= starve_cnt_d;
      rr_last_q    <= rr_last_d;
    end
  end

  // Next-state logic
  always_comb begin
    resp_d       = resp_q;
    starve_cnt_d = starve_cnt_q;
    rr_last_d    = rr_last_q;

    resp_d.vld = issue;
    if (issue) begin
      resp_d.owner = gnt_data ? OWN_DATA : OWN_INST;
    end

`ifdef ARB_RR_EN
    starve_cnt_d = '0;
    if (issue) begin
      rr_last_d = gnt_data ? OWN_DATA : OWN_INST;
    end
`else
    // Counts data wins that happened while fetch was waiting; saturates at the limit.
    if (!bus.inst_req || gnt_inst) begin
      starve_cnt_d = '0;
    end else if (gnt_data && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
`endif
  end

  // Output logic
  always_comb begin
    issue_addr  = gnt_data ? bus.data_addr : bus.inst_addr;
    issue_wdata = bus.data_wdata;

    bus.inst_addr_ok = resetn & gnt_inst;
    bus.data_addr_ok = resetn & gnt_data;

    bus.sram_en    = resetn & issue;
    bus.sram_we    = (resetn && gnt_data && bus.data_wr) ? bus.data_wstrb : '0;
    bus.sram_addr  = issue_addr;
    bus.sram_wdata = issue_wdata;

    // A cancel only hides a fetch response already in flight, never a fresh accept.
    bus.inst_data_ok = resetn & resp_q.vld & (resp_q.owner == OWN_INST) & ~bus.inst_cancel;
    bus.data_data_ok = resetn & resp_q.vld & (resp_q.owner == OWN_DATA);

    bus.inst_rdata = bus.sram_rdata;
    bus.data_rdata = bus.sram_rdata;
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!resetn)
    !(gnt_inst && gnt_data));

  a_data_latency: assert property (@(posedge clk) disable iff (!resetn)
    bus.data_addr_ok |=> bus.data_data_ok);

endmodule
